// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: issues operands, watches the result.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    // Adder side: consumes operands, returns the result.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder slice walked LSB first over WIDTH
// clocks, with a start/done handshake and a held result register.

// Single-bit half adder; two of these plus an OR form the shared slice.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] sa_q, sa_n;
    logic [WIDTH-1:0] sb_q, sb_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic             carry_q, carry_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] sum_q, sum_n;
    logic             cout_q, cout_n;
    logic             busy_q;
    logic             done_q;

    logic             s0, c0, c1, sum_bit, carry_out;
    logic [WIDTH-1:0] acc_shift;

    // Shared full-adder slice on the current LSBs and the running carry.
    half_adder u_ha0 (.x(sa_q[0]), .y(sb_q[0]), .s(s0),      .c(c0));
    half_adder u_ha1 (.x(s0),      .y(carry_q), .s(sum_bit), .c(c1));

    assign carry_out = c0 | c1;

    // New sum bit enters at the MSB so the LSB-first stream lands in order.
    assign acc_shift = (acc_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        sa_n    = sa_q;
        sb_n    = sb_q;
        acc_n   = acc_q;
        carry_n = carry_q;
        cnt_n   = cnt_q;
        sum_n   = sum_q;
        cout_n  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_n    = bus.a;
                    sb_n    = bus.b;
                    carry_n = 1'b0;
                    cnt_n   = '0;
                    acc_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                acc_n   = acc_shift;
                sa_n    = sa_q >> 1;
                sb_n    = sb_q >> 1;
                carry_n = carry_out;
                cnt_n   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_n   = acc_shift;
                    cout_n  = carry_out;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sa_q    <= sa_n;
            sb_q    <= sb_n;
            acc_q   <= acc_n;
            carry_q <= carry_n;
            cnt_q   <= cnt_n;
            sum_q   <= sum_n;
            cout_q  <= cout_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= (state_n == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
